// File: rtl/stepper_motion_ctrl.sv
// Goalie stepper position controller: homes against the limit switch after reset,
// then steps toward the clamped target at a fixed rate and reports pos/homed/busy.
module stepper_motion_ctrl #(
   parameter int unsigned      POS_W         = 16,
   parameter logic [POS_W-1:0] MAX_POS       = POS_W'(1600),
   parameter int unsigned      STEP_PERIOD   = 50000,
   parameter int unsigned      PULSE_WIDTH   = 200,
   parameter int unsigned      DIR_SETUP     = 100,
   parameter int unsigned      BACKOFF_STEPS = 20,
   parameter logic [2:0]       MSTEP         = 3'b000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] target,
   input  logic        limit_switch,
   output logic [5:0]  JA,
   output logic [31:0] status
);

   localparam int unsigned TMR_W = $clog2(STEP_PERIOD + 1);
   localparam int unsigned CNT_W = $clog2(BACKOFF_STEPS + 1);
   localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(STEP_PERIOD - 1);
   localparam logic [TMR_W-1:0] TMR_SETUP = TMR_W'(STEP_PERIOD - DIR_SETUP);
   localparam logic [TMR_W-1:0] TMR_PULSE = TMR_W'(PULSE_WIDTH - 1);
   localparam logic [CNT_W-1:0] CNT_DONE  = CNT_W'(BACKOFF_STEPS);

   typedef enum logic [1:0] {StSeek, StBackoff, StIdle, StMove} state_e;

   state_e             state_q, state_d;
   logic [TMR_W-1:0]   tmr_q, tmr_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [POS_W-1:0]   pos_q, pos_d;
   logic               step_q, step_d;
   logic               dir_q, dir_d;
   logic               homed_q, homed_d;
   logic               en_n_q;
   logic [1:0]         sync_q;
   logic [31:0]        status_q, status_d;

   logic               lim_s;
   logic               dp;
   logic               take_step;
   logic               change;
   logic               new_dir;
   logic [POS_W-1:0]   tgt_c;
   logic               unused_target;

   assign lim_s = sync_q[1];
   assign dp    = (tmr_q == TMR_LAST);
   assign tgt_c = (target[POS_W-1:0] > MAX_POS) ? MAX_POS : target[POS_W-1:0];
   assign unused_target = ^target[31:POS_W];

   always_comb begin
      state_d   = state_q;
      tmr_d     = dp ? '0 : tmr_q + 1'b1;
      cnt_d     = cnt_q;
      pos_d     = pos_q;
      step_d    = step_q;
      dir_d     = dir_q;
      homed_d   = homed_q;
      take_step = 1'b0;
      change    = 1'b0;
      new_dir   = dir_q;

      if (step_q && tmr_q == TMR_PULSE) begin
         step_d = 1'b0;
      end

      if (dp) begin
         unique case (state_q)
            StSeek: begin
               if (lim_s) begin
                  state_d = StBackoff;
                  pos_d   = '0;
                  cnt_d   = '0;
                  new_dir = 1'b1;
                  change  = 1'b1;
               end else begin
                  take_step = 1'b1;
               end
            end
            StBackoff: begin
               if (cnt_q == CNT_DONE) begin
                  state_d = StIdle;
                  pos_d   = '0;
                  homed_d = 1'b1;
               end else begin
                  take_step = 1'b1;
                  cnt_d     = cnt_q + 1'b1;
               end
            end
            StIdle: begin
               if (tgt_c != pos_q) begin
                  state_d = StMove;
                  new_dir = (tgt_c > pos_q);
                  change  = 1'b1;
               end
            end
            StMove: begin
               // Switch hit while heading home off-zero means lost steps: re-home.
               if (lim_s && !dir_q && pos_q != '0) begin
                  state_d = StBackoff;
                  homed_d = 1'b0;
                  cnt_d   = '0;
                  new_dir = 1'b1;
                  change  = 1'b1;
               end else if (tgt_c == pos_q) begin
                  state_d = StIdle;
               end else if ((tgt_c > pos_q) != dir_q) begin
                  new_dir = (tgt_c > pos_q);
                  change  = 1'b1;
               end else begin
                  take_step = 1'b1;
               end
            end
            default: ;
         endcase
      end

      // Direction change: next edge comes DIR_SETUP cycles after dir settles.
      if (change) begin
         dir_d = new_dir;
         tmr_d = TMR_SETUP;
      end

      if (take_step && (state_q == StSeek || (dir_q ? (pos_q != MAX_POS) : (pos_q != '0)))) begin
         step_d = 1'b1;
         if (state_q == StMove) begin
            pos_d = dir_q ? pos_q + 1'b1 : pos_q - 1'b1;
         end
      end

      status_d = {14'd0, (state_d == StMove), homed_d, 16'(pos_d)};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StSeek;
         tmr_q    <= '0;
         cnt_q    <= '0;
         pos_q    <= '0;
         step_q   <= 1'b0;
         dir_q    <= 1'b0;
         homed_q  <= 1'b0;
         en_n_q   <= 1'b1;
         sync_q   <= 2'b00;
         status_q <= '0;
      end else begin
         state_q  <= state_d;
         tmr_q    <= tmr_d;
         cnt_q    <= cnt_d;
         pos_q    <= pos_d;
         step_q   <= step_d;
         dir_q    <= dir_d;
         homed_q  <= homed_d;
         en_n_q   <= 1'b0;
         sync_q   <= {sync_q[0], limit_switch};
         status_q <= status_d;
      end
   end

   assign JA     = {MSTEP, en_n_q, dir_q, step_q};
   assign status = status_q;

endmodule

// File: tb/tb_stepper_motion_ctrl.sv
// Scoreboard bench: expected step events are queued by the stimulus from a position
// model; a negedge monitor checks each step edge, spacing, setup and pulse width.
module tb_stepper_motion_ctrl;

   localparam int P    = 8;
   localparam int PW   = 2;
   localparam int DS   = 2;
   localparam int BO   = 4;
   localparam int MAXP = 100;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] target = '0;
   logic        limit_switch = 1'b0;
   logic [5:0]  JA;
   logic [31:0] status;

   stepper_motion_ctrl #(
      .POS_W(16), .MAX_POS(16'd100), .STEP_PERIOD(P), .PULSE_WIDTH(PW),
      .DIR_SETUP(DS), .BACKOFF_STEPS(BO), .MSTEP(3'b000)
   ) dut (
      .clk(clk), .rst_n(rst_n), .target(target), .limit_switch(limit_switch),
      .JA(JA), .status(status)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit dir;
      int pos;
      bit homed;
      bit busy;
      int gap;
   } step_t;

   step_t exp_q[$];
   int    checks = 0;
   int    passes = 0;
   int    model_pos = 0;

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act == exp) passes++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   task automatic push(input bit d, input int p, input bit h, input bit b, input int g);
      step_t e;
      e.dir = d; e.pos = p; e.homed = h; e.busy = b; e.gap = g;
      exp_q.push_back(e);
   endtask

   task automatic push_move(input logic [31:0] t);
      int tgt;
      int g;
      bit d;
      tgt = (t[15:0] > 16'(MAXP)) ? MAXP : int'(t[15:0]);
      g = 0;
      while (model_pos != tgt) begin
         d = (tgt > model_pos);
         model_pos += d ? 1 : -1;
         push(d, model_pos, 1'b1, 1'b1, g);
         g = P;
      end
   endtask

   task automatic wait_idle(input logic [31:0] exp_status);
      int n;
      n = 0;
      repeat (P + 2) @(negedge clk);
      while ((status[17] || !status[16]) && n < 20000) begin
         @(negedge clk);
         n++;
      end
      chk("idle_timeout", n < 20000, 1);
      chk("idle_status", status, exp_status);
      chk("queue_drained", exp_q.size(), 0);
   endtask

   task automatic wait_pos(input int p);
      int n;
      n = 0;
      while (int'(status[15:0]) != p && n < 20000) begin
         @(negedge clk);
         n++;
      end
      chk("pos_timeout", n < 20000, 1);
   endtask

   // Monitor
   int    cyc = 0;
   int    last_rise = -1;
   int    rise_at = 0;
   int    dir_run = 0;
   bit    prev_step = 0;
   bit    prev_dir = 0;
   step_t mon_e;

   always @(negedge clk) begin
      if (!rst_n) begin
         prev_step = 0;
         prev_dir  = JA[1];
         dir_run   = 0;
         last_rise = -1;
      end else begin
         cyc++;
         if (JA[1] == prev_dir) dir_run++;
         else dir_run = 0;
         prev_dir = JA[1];
         if (JA[0] && !prev_step) begin
            chk("dir_setup", dir_run >= DS, 1);
            chk("step_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
               mon_e = exp_q.pop_front();
               chk("step_dir", JA[1], mon_e.dir);
               chk("step_status", status,
                   {14'd0, mon_e.busy, mon_e.homed, 16'(mon_e.pos)});
               if (mon_e.gap != 0 && last_rise >= 0)
                  chk("step_gap", cyc - last_rise, mon_e.gap);
            end
            last_rise = cyc;
            rise_at   = cyc;
         end
         if (!JA[0] && prev_step) chk("pulse_width", cyc - rise_at, PW);
         prev_step = JA[0];
      end
   end

   initial begin
      int n;
      int seen;
      bit prev;
      logic [31:0] t;

      for (int i = 0; i < 5; i++) push(1'b0, 0, 1'b0, 1'b0, (i == 0) ? 0 : P);
      for (int i = 0; i < BO; i++) push(1'b1, 0, 1'b0, 1'b0, (i == 0) ? P + DS : P);

      repeat (3) @(negedge clk);
      chk("reset_status", status, 0);
      chk("reset_ja", JA, 6'b000100);
      rst_n = 1'b1;

      n = 0;
      do begin
         @(posedge clk); #1;
         n++;
      end while (!JA[0] && n < 100);
      chk("first_step_latency", n, P);

      seen = 1; prev = 1; n = 0;
      while (seen < 5 && n < 1000) begin
         @(negedge clk);
         n++;
         if (JA[0] && !prev) seen++;
         prev = JA[0];
      end
      chk("seek_steps_timeout", seen, 5);
      limit_switch = 1'b1;
      wait_idle(32'h0001_0000);
      limit_switch = 1'b0;
      model_pos = 0;

      push_move(32'd10);
      target = 32'd10;
      wait_idle(32'h0001_000A);

      push_move(32'd0);
      target = 32'd0;
      wait_idle(32'h0001_0000);

      // Reversal: up to 6, then target drops to 3 right after the pos=6 edge
      for (int p = 1; p <= 6; p++) push(1'b1, p, 1'b1, 1'b1, (p == 1) ? 0 : P);
      for (int p = 5; p >= 3; p--) push(1'b0, p, 1'b1, 1'b1, (p == 5) ? P + DS : P);
      model_pos = 3;
      target = 32'd10;
      wait_pos(6);
      target = 32'd3;
      wait_idle(32'h0001_0003);

      for (int i = 0; i < 6; i++) begin
         t = $urandom();
         t[15:0] = 16'($urandom_range(130, 0));
         push_move(t);
         target = t;
         wait_idle({14'd0, 1'b0, 1'b1, 16'(model_pos)});
      end

      t = 32'hFFFF_0200;
      push_move(t);
      target = t;
      wait_idle(32'h0001_0064);
      repeat (3 * P) @(negedge clk);
      chk("clamp_hold", status, 32'h0001_0064);

      // Fault: heading home, switch trips at pos=7
      for (int p = model_pos - 1; p >= 7; p--)
         push(1'b0, p, 1'b1, 1'b1, (p == model_pos - 1) ? 0 : P);
      for (int i = 0; i < BO; i++) push(1'b1, 7, 1'b0, 1'b0, (i == 0) ? P + DS : P);
      target = 32'd0;
      wait_pos(7);
      limit_switch = 1'b1;
      wait_idle(32'h0001_0000);
      limit_switch = 1'b0;
      model_pos = 0;

      push_move(32'd50);
      target = 32'd50;
      n = 0;
      do begin
         @(posedge clk); #1;
         n++;
      end while (!JA[0] && n < 200);
      chk("step_before_reset", JA[0], 1);
      rst_n = 1'b0;
      #1;
      chk("reset_ja_async", JA[2:0], 3'b100);
      chk("reset_status_async", status, 0);
      exp_q.delete();
      repeat (2) @(negedge clk);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
